// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared widths, defaults and state encoding for the branch redirect controller.
package branch_redirect_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF    = 16;
  localparam int unsigned FLUSH_CYC_DEF = 2;
  localparam int unsigned CNT_W_DEF     = 16;

  // Encoding is fixed so pipeline monitor/trace logic can decode it directly.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_REDIRECT = 2'b01,
    ST_DRAIN    = 2'b10,
    ST_ILLEGAL  = 2'b11
  } redirect_state_e;

  // Drain counter only needs to hold FLUSH_CYC-1; keep at least one bit.
  function automatic int unsigned drain_width(input int unsigned flush_cyc);
    return (flush_cyc > 1) ? $clog2(flush_cyc) : 1;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl.sv
// Redirects fetch after a taken exec-stage branch: squashes IF/ID/EX, hands the
// target PC to fetch over valid/ready, then drains in-flight fetches.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR      = ADDR_W_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_i,
  input  logic [ADDR-1:0]  branch_addr_i,
  input  logic             stall_i,
  input  logic             fetch_rdy_i,
  output logic             pc_load_o,
  output logic [ADDR-1:0]  pc_load_addr_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  localparam int unsigned DRAIN_W = drain_width(FLUSH_CYC);

  redirect_state_e    r_state;
  logic               r_pc_load;
  logic [ADDR-1:0]    r_addr;
  logic               r_flush_if;
  logic               r_flush_id;
  logic               r_flush_ex;
  logic               r_busy;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]   r_taken_cnt;

  redirect_state_e    w_state_nxt;
  logic               w_pc_load_nxt;
  logic [ADDR-1:0]    w_addr_nxt;
  logic               w_flush_if_nxt;
  logic               w_flush_id_nxt;
  logic               w_flush_ex_nxt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [CNT_W-1:0]   w_taken_nxt;

  // Next-state and next-output decode; every output is registered from here.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_load_nxt  = r_pc_load;
    w_addr_nxt     = r_addr;
    w_flush_if_nxt = 1'b0;
    w_flush_id_nxt = 1'b0;
    w_flush_ex_nxt = 1'b0;
    w_drain_nxt    = r_drain_cnt;
    w_taken_nxt    = r_taken_cnt;

    case (r_state)
      ST_IDLE: begin
        if (branch_i && !stall_i) begin
          w_state_nxt    = ST_REDIRECT;
          w_pc_load_nxt  = 1'b1;
          w_addr_nxt     = branch_addr_i;
          w_flush_if_nxt = 1'b1;
          w_flush_id_nxt = 1'b1;
          w_flush_ex_nxt = 1'b1;
          w_taken_nxt    = r_taken_cnt + CNT_W'(1);
        end
      end
      ST_REDIRECT: begin
        // Branches seen while busy come from squashed instructions: ignored.
        if (r_pc_load && fetch_rdy_i) begin
          w_pc_load_nxt = 1'b0;
          if (FLUSH_CYC > 0) begin
            w_state_nxt    = ST_DRAIN;
            w_drain_nxt    = DRAIN_W'(FLUSH_CYC - 1);
            w_flush_if_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_flush_if_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_drain_nxt    = r_drain_cnt - DRAIN_W'(1);
          w_flush_if_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pc_load_nxt = 1'b0;
        w_drain_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc_load   <= 1'b0;
      r_addr      <= '0;
      r_flush_if  <= 1'b0;
      r_flush_id  <= 1'b0;
      r_flush_ex  <= 1'b0;
      r_busy      <= 1'b0;
      r_drain_cnt <= '0;
      r_taken_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_addr      <= w_addr_nxt;
      r_flush_if  <= w_flush_if_nxt;
      r_flush_id  <= w_flush_id_nxt;
      r_flush_ex  <= w_flush_ex_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_drain_cnt <= w_drain_nxt;
      r_taken_cnt <= w_taken_nxt;
    end
  end

  assign pc_load_o      = r_pc_load;
  assign pc_load_addr_o = r_addr;
  assign flush_if_o     = r_flush_if;
  assign flush_id_o     = r_flush_id;
  assign flush_ex_o     = r_flush_ex;
  assign busy_o         = r_busy;
  assign taken_cnt_o    = r_taken_cnt;

endmodule
